// File: rtl/bomb_game_ctrl_if.sv
// Link between the game sequencer and the password-check block.
// master: sequencer side (drives enable, clear and password; receives match flag).
// slave : checker side.
interface bomb_game_ctrl_if;
  logic       startInput;  // checker enable
  logic       chk_rst;     // active-low checker clear
  logic [6:0] psw;         // latched password
  logic       success;     // registered match flag from the checker

  modport master (
    output startInput,
    output chk_rst,
    output psw,
    input  success
  );

  modport slave (
    input  startInput,
    input  chk_rst,
    input  psw,
    output success
  );
endinterface

// File: rtl/bomb_game_ctrl.sv
// Bomb-game sequencer: arms with a switch password, counts seconds down,
// gates/clears the password checker, counts wrong tries, decides defused/exploded.
// Ports: clk, rst (async active-low), SW, BTN7 (arm/restart), BTN6 (confirm),
//        chk (checker link, master side), sec_left, tries_left, beep, defused, exploded.
module bomb_game_ctrl #(
  parameter int TICK_DIV   = 50_000_000,
  parameter int COUNT_INIT = 60,
  parameter int MAX_TRIES  = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [6:0]                SW,
  input  logic                      BTN7,
  input  logic                      BTN6,
  bomb_game_ctrl_if.master          chk,
  output logic [6:0]                sec_left,
  output logic [1:0]                tries_left,
  output logic                      beep,
  output logic                      defused,
  output logic                      exploded
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_CHECK,
    S_DEFUSED,
    S_EXPLODED
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] tick_cnt, tick_cnt_nxt;
  logic [6:0]    psw_q, psw_nxt;
  logic [6:0]    sec_q, sec_nxt;
  logic [1:0]    tries_q, tries_nxt;
  logic          b6_prev, b7_prev;
  logic          btn6_rise, btn7_rise;
  logic          counting, tick, timeout;

  assign btn6_rise = BTN6 & ~b6_prev;
  assign btn7_rise = BTN7 & ~b7_prev;

  // The seconds counter runs in both ARMED and CHECK so a confirm never
  // steals time from the countdown.
  assign counting = (state == S_ARMED) || (state == S_CHECK);
  assign tick     = counting && (tick_cnt == TICK_LAST);
  // Tick that takes the last remaining second.
  assign timeout  = tick && (sec_q <= 7'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      psw_q    <= '0;
      sec_q    <= '0;
      tries_q  <= '0;
      b6_prev  <= 1'b0;
      b7_prev  <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      psw_q    <= psw_nxt;
      sec_q    <= sec_nxt;
      tries_q  <= tries_nxt;
      b6_prev  <= BTN6;
      b7_prev  <= BTN7;
    end
  end

  always_comb begin
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    psw_nxt      = psw_q;
    sec_nxt      = sec_q;
    tries_nxt    = tries_q;

    if (counting) begin
      tick_cnt_nxt = tick ? '0 : tick_cnt + CW'(1);
      if (tick && (sec_q != 7'd0)) begin
        sec_nxt = sec_q - 7'd1;
      end
    end

    case (state)
      S_IDLE: begin
        if (btn7_rise) begin
          psw_nxt      = SW;
          sec_nxt      = 7'(COUNT_INIT);
          tries_nxt    = 2'(MAX_TRIES);
          tick_cnt_nxt = '0;
          state_nxt    = S_ARMED;
        end
      end
      S_ARMED: begin
        // Running out of time outranks a confirm landing on the same tick.
        if (timeout) begin
          state_nxt = S_EXPLODED;
        end else if (btn6_rise) begin
          state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (chk.success) begin
          state_nxt = S_DEFUSED;
        end else begin
          if (tries_q != 2'd0) begin
            tries_nxt = tries_q - 2'd1;
          end
          if ((tries_q <= 2'd1) || timeout) begin
            state_nxt = S_EXPLODED;
          end else begin
            state_nxt = S_ARMED;
          end
        end
      end
      S_DEFUSED, S_EXPLODED: begin
        if (btn7_rise) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only.
  assign chk.startInput = (state == S_ARMED);
  assign chk.chk_rst    = (state != S_IDLE);
  assign chk.psw        = psw_q;
  assign sec_left       = sec_q;
  assign tries_left     = tries_q;
  assign beep           = tick && (state == S_ARMED);
  assign defused        = (state == S_DEFUSED);
  assign exploded       = (state == S_EXPLODED);

endmodule

// File: doc/bomb_game_ctrl.md
# bomb_game_ctrl

Top-level sequencer for the bomb-dismantlement game. It arms the bomb with a password latched from the switches and runs a seconds countdown. It gates and clears the downstream password-check block, counts wrong attempts, and declares the bomb defused or exploded. It sits between the board buttons and switches, the password-check block (`startInput`/`psw`/`success`) and the display/buzzer logic.

## Interface
Parameters:
- `TICK_DIV`, 50_000_000: clock cycles per countdown second; must be ≥2.
- `COUNT_INIT`, 60: countdown start value in seconds, 1..99.
- `MAX_TRIES`, 3: wrong confirmations allowed before explosion, 1..3.

Ports:
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `SW`  in  7  switch value; latched as the password at arming.
- `BTN7`  in  1  arm / restart button, debounced and synchronous. Its rising edge is the event.
- `BTN6`  in  1  confirm button, same signal as used by the checker. Its rising edge is the event.
- `success`  in  1  registered match flag from the checker.
- `startInput`  out  1  enables the checker; 1 only in ARMED.
- `chk_rst`  out  1  active-low clear to the checker; 0 in IDLE, 1 otherwise.
- `psw`  out  7  latched password.
- `sec_left`  out  7  remaining seconds, binary.
- `tries_left`  out  2  remaining wrong attempts.
- `beep`  out  1  one-cycle pulse on each second tick while ARMED.
- `defused`  out  1  1 in DEFUSED.
- `exploded`  out  1  1 in EXPLODED.

## Operation
- Edge detect: `b6_prev` and `b7_prev` are registers. `btnX_rise = BTNX & ~bX_prev`. Both previous-value registers reset to 0.
- The state machine has five states: IDLE, ARMED, CHECK, DEFUSED, EXPLODED. Reset state is IDLE.
- IDLE:
  - On `btn7_rise`: `psw <= SW`, `sec_left <= COUNT_INIT`, `tries_left <= MAX_TRIES`, tick counter <= 0, go to ARMED.
- ARMED:
  - The tick counter runs 0..TICK_DIV-1. At TICK_DIV-1 it wraps to 0, `beep` = 1 for that cycle, and `sec_left` decrements.
  - If the tick occurs with `sec_left == 1`, then `sec_left <= 0` and the next state is EXPLODED.
  - `btn6_rise` moves to CHECK. If a tick happens in the same cycle, the tick is still applied.
  - `btn7_rise` is ignored.
- CHECK (exactly one cycle):
  - The tick counter keeps running.
  - If `success == 1`, go to DEFUSED. Success has priority over a timeout in that same cycle.
  - Otherwise `tries_left` decrements. If the result is 0, or `sec_left` reaches 0 this cycle, go to EXPLODED; else return to ARMED.
- DEFUSED / EXPLODED:
  - The counter freezes and `sec_left` and `tries_left` hold.
  - `btn7_rise` moves to IDLE, which clears the checker via `chk_rst`.
- Arithmetic:
  - `sec_left` never decrements below 0 and `tries_left` never below 0.
  - The counter width is ceil(log2(TICK_DIV)).
  - `startInput` is 0 in CHECK, so the checker ignores switch traffic during evaluation.

## Timing
- Reset values:
  - `psw` = 0, `sec_left` = 0, `tries_left` = 0, tick counter = 0.
  - `startInput` = 0, `chk_rst` = 0, `beep` = 0, `defused` = 0, `exploded` = 0.
- All outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.
- Arming: for a `btn7_rise` in cycle N, `startInput` = 1 and `chk_rst` = 1 from cycle N+1. The first tick occurs TICK_DIV cycles after entry.
- Confirm: `btn6_rise` in cycle N means the checker samples in N, CHECK is in N+1 (samples `success`), and `defused` is 1 or ARMED resumes at N+2.
- Expiry: `exploded` = 1 the cycle after the tick that brings `sec_left` to 0.
- Reset asserted mid-game returns to IDLE immediately, with all outputs at their reset values.

## Test plan
- Reset then arm: with TICK_DIV=4, COUNT_INIT=3, SW=7'h55, pulse BTN7. Expect `psw` = 55h, `sec_left` = 3, `startInput` = 1, `beep` every 4 cycles, `sec_left` 3→2→1→0, and `exploded` = 1 at cycle 13.
- Correct password: arm, then drive `success` = 1 the cycle after a BTN6 rise. Expect `defused` = 1 two cycles after the rise, `sec_left` frozen, `startInput` = 0.
- Wrong attempts with MAX_TRIES=3: three BTN6 rises with `success` = 0. Expect `tries_left` 3→2→1→0, and `exploded` after the third attempt.
- Held BTN6: hold it high for 10 cycles. Expect exactly one CHECK and a single `tries_left` decrement.
- Collision: the BTN6 rise lands so that CHECK coincides with the final tick. With `success` = 1 expect `defused`; with `success` = 0 expect `exploded`.
- Restart and async reset: BTN7 in EXPLODED gives IDLE with `chk_rst` = 0. Re-arm and then assert `rst` mid-countdown; all outputs return to 0 within the same cycle.
